// File: rtl/prod_accum_pkg.sv
// prod_accum_pkg: shared types and default sizes for the product accumulator.
//   state_t        FSM state encoding (S_IDLE, S_ACC, S_DONE)
//   DEF_N, DEF_M   default operand widths of the upstream multiplier
//   DEF_ACC_W      default accumulator width (product width plus 8 guard bits)
//   DEF_CNT_W      default width of the product-count field
package prod_accum_pkg;
   localparam int DEF_N = 4;
   localparam int DEF_M = 5;
   localparam int DEF_ACC_W = DEF_N + DEF_M + 8;
   localparam int DEF_CNT_W = 8;
   typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;
endpackage

// File: rtl/rca_Nbit_co.sv
// rca_Nbit_co: W-bit ripple-carry adder with carry out.
//   a, b   W-bit unsigned addends
//   cin    carry in
//   s      W-bit sum
//   co     carry out of bit W-1
module rca_Nbit_co #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         co
);
   logic [W:0] c;
   assign c[0] = cin;
   for (genvar i = 0; i < W; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign co = c[W];
endmodule

// File: rtl/prod_accum.sv
// prod_accum: sums a programmed number of multiplier products into an accumulator.
//   clk, rst     rising-edge clock, synchronous active-high reset
//   start, len   begin a run of len products (honoured only when idle)
//   prod_valid, prod, prod_ready   product input handshake
//   acc_valid, acc_out, acc_ready  result output handshake
//   busy         high while accumulating or holding a result
//   ovf          sticky carry-out flag for the current run
// Build option: define PROD_ACCUM_SAT_EN to saturate on overflow instead of wrapping.
module prod_accum
   import prod_accum_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int M     = DEF_M,
   parameter int ACC_W = N + M + 8,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             prod_valid,
   input  logic [N+M-1:0]   prod,
   output logic             prod_ready,
   output logic             acc_valid,
   output logic [ACC_W-1:0] acc_out,
   input  logic             acc_ready,
   output logic             busy,
   output logic             ovf
);
   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] sum;
   logic [CNT_W-1:0] rem;
   logic             co;
   rca_Nbit_co #(.W(ACC_W)) u_add (
      .a   (acc),
      .b   (ACC_W'(prod)),
      .cin (1'b0),
      .s   (sum),
      .co  (co)
   );
   assign prod_ready = state == S_ACC;
   assign acc_valid  = state == S_DONE;
   assign busy       = state != S_IDLE;
   assign acc_out    = acc;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         acc   <= '0;
         rem   <= '0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            S_IDLE:
               if (start) begin
                  acc   <= '0;
                  ovf   <= 1'b0;
                  rem   <= len;
                  state <= len != '0 ? S_ACC : S_DONE;
               end
            S_ACC:
               if (prod_valid) begin
`ifdef PROD_ACCUM_SAT_EN
                  // once overflowed, the accumulator is pinned at all ones
                  acc <= (co | ovf) ? '1 : sum;
`else
                  acc <= sum;
`endif
                  ovf <= ovf | co;
                  rem <= rem - 1'b1;
                  if (rem == CNT_W'(1)) state <= S_DONE;
               end
            S_DONE:
               if (acc_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: scoreboard bench driving a 17-bit and a 10-bit accumulator in lockstep.
module tb_prod_accum;
   localparam int SAT =
`ifdef PROD_ACCUM_SAT_EN
      1;
`else
      0;
`endif
   typedef struct {
      logic [16:0] a;
      logic        oa;
      logic [9:0]  b;
      logic        ob;
   } exp_t;
   logic        clk = 0;
   logic        rst = 1;
   logic        start = 0;
   logic [7:0]  len = 0;
   logic        prod_valid = 0;
   logic [8:0]  prod = 0;
   logic        acc_ready = 1;
   logic        ready_a, valid_a, busy_a, ovf_a;
   logic        ready_b, valid_b, busy_b, ovf_b;
   logic [16:0] out_a;
   logic [9:0]  out_b;
   int          nchk = 0;
   int          nerr = 0;
   int          cyc = 0;
   int          t0 = 0;
   exp_t        q[$];
   prod_accum u_a (
      .clk(clk), .rst(rst), .start(start), .len(len), .prod_valid(prod_valid), .prod(prod),
      .prod_ready(ready_a), .acc_valid(valid_a), .acc_out(out_a), .acc_ready(acc_ready),
      .busy(busy_a), .ovf(ovf_a)
   );
   prod_accum #(.ACC_W(10)) u_b (
      .clk(clk), .rst(rst), .start(start), .len(len), .prod_valid(prod_valid), .prod(prod),
      .prod_ready(ready_b), .acc_valid(valid_b), .acc_out(out_b), .acc_ready(acc_ready),
      .busy(busy_b), .ovf(ovf_b)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask
   function automatic void push(input int a, input int oa, input int b, input int ob);
      exp_t e;
      e.a = 17'(a);
      e.oa = oa[0];
      e.b = 10'(b);
      e.ob = ob[0];
      q.push_back(e);
   endfunction
   always @(negedge clk) begin
      if (!rst && (valid_a || valid_b)) begin
         chk("valid_pair", 32'(valid_b), 32'(valid_a));
         if (q.size() == 0) chk("unexpected_result", 32'(valid_a), 32'd0);
         else begin
            chk("acc_out_17", 32'(out_a), 32'(q[0].a));
            chk("ovf_17", 32'(ovf_a), 32'(q[0].oa));
            chk("acc_out_10", 32'(out_b), 32'(q[0].b));
            chk("ovf_10", 32'(ovf_b), 32'(q[0].ob));
            if (acc_ready) void'(q.pop_front());
         end
      end
   end
   task automatic start_run(input int l);
      @(posedge clk); #1;
      start = 1;
      len = 8'(l);
      @(posedge clk); #1;
      t0 = cyc;
      start = 0;
   endtask
   task automatic send(input int p);
      bit ok = 0;
      prod_valid = 1;
      prod = 9'(p);
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (ready_a) begin
            ok = 1;
            @(posedge clk); #1;
         end
      end
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
      prod_valid = 0;
   endtask
   task automatic drain();
      for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      @(posedge clk); #1;
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready_a), 32'd0);
      chk("rst_valid", 32'(valid_a), 32'd0);
      chk("rst_out", 32'(out_a), 32'd0);
      chk("rst_busy", 32'(busy_a | busy_b), 32'd0);
      chk("rst_ovf", 32'(ovf_a | ovf_b), 32'd0);
      rst = 0;
      // basic: 465 + 1 + 10
      push(476, 0, 476, 0);
      start_run(3);
      chk("start_to_ready", 32'(ready_a), 32'd1);
      send(465);
      send(1);
      send(10);
      chk("valid_after_last", 32'(valid_a), 32'd1);
      drain();
      chk("basic_idle", 32'(busy_a), 32'd0);
      // empty run
      push(0, 0, 0, 0);
      start_run(0);
      chk("empty_valid", 32'(valid_a), 32'd1);
      chk("empty_ready", 32'(ready_a), 32'd0);
      drain();
      // gaps and backpressure
      acc_ready = 0;
      push(16, 0, 16, 0);
      start_run(2);
      send(7);
      repeat (3) @(posedge clk);
      #1;
      send(9);
      for (int i = 0; i < 5; i++) begin
         chk("done_ready", 32'(ready_a), 32'd0);
         chk("done_busy", 32'(busy_a), 32'd1);
         start = i == 2;
         len = 8'd1;
         @(posedge clk); #1;
      end
      start = 1;
      len = 8'd5;
      acc_ready = 1;
      @(posedge clk); #1;
      start = 0;
      chk("handshake_start_ignored", 32'(busy_a), 32'd0);
      drain();
      // overflow: 3 x 465 = 1395
      push(1395, 0, SAT ? 1023 : 371, 1);
      start_run(3);
      repeat (3) send(465);
      drain();
      // reset mid-run
      start_run(4);
      send(5);
      send(5);
      prod_valid = 1;
      prod = 9'd7;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      prod_valid = 0;
      chk("abort_busy", 32'(busy_a | busy_b), 32'd0);
      chk("abort_out", 32'(out_a), 32'd0);
      chk("abort_ovf", 32'(ovf_a), 32'd0);
      chk("abort_ready", 32'(ready_a), 32'd0);
      chk("abort_valid", 32'(valid_a), 32'd0);
      push(5, 0, 5, 0);
      start_run(1);
      send(5);
      drain();
      // max length: 255 x 465 = 118575
      push(118575, 0, SAT ? 1023 : 815, 1);
      start_run(255);
      repeat (255) send(465);
      chk("max_latency", 32'(cyc - t0), 32'd255);
      chk("max_valid", 32'(valid_a), 32'd1);
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end
endmodule
